// File: rtl/board_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : board_read_arbiter
// Purpose  : Shares the single read port of the Tetris board cell memory
//            between the VGA pixel fetch, the game logic and the UART dump.
//            VGA has priority; game and dump share the remaining slots
//            round-robin; a game request that has waited STARVE_LIMIT
//            cycles pre-empts the VGA for one slot. Every response has a
//            fixed 3-cycle latency (grant +1, memory data +2, rvalid +3).
// Ports    : clk, reset                       clock, sync active-high reset
//            vga_req/x/y -> vga_rvalid/rdata/miss   fire-and-forget reads
//            game_req/x/y -> game_gnt/rvalid/rdata  level request + grant
//            dbg_req/x/y  -> dbg_gnt/rvalid/rdata   level request + grant
//            mem_en/mem_addr -> mem_rdata     1-cycle-latency memory port
//            stat_miss_cnt                    VGA miss counter (optional)
// Config   : define BOARD_ARB_STATS_EN to build the stat_miss_cnt port and
//            its saturating counter; arbitration is identical either way.
// Revision : 1.0 - initial release
// ============================================================================
module board_read_arbiter #(
  parameter int BOARD_W      = 10,
  parameter int BOARD_H      = 20,
  parameter int DATA_W       = 3,
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [3:0]        vga_x,
  input  logic [4:0]        vga_y,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_miss,
  input  logic              game_req,
  input  logic [3:0]        game_x,
  input  logic [4:0]        game_y,
  output logic              game_gnt,
  output logic              game_rvalid,
  output logic [DATA_W-1:0] game_rdata,
  input  logic              dbg_req,
  input  logic [3:0]        dbg_x,
  input  logic [4:0]        dbg_y,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef BOARD_ARB_STATS_EN
  ,
  output logic [15:0]       stat_miss_cnt
`endif
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] c_STARVE_LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_wait_cnt;
  logic          r_rr_dbg;       // 1 = dbg wins the next contested round-robin slot

  // Response tags travelling alongside the memory read
  logic r_s1_vga, r_s1_miss, r_s1_gd, r_s1_dbg;
  logic r_s2_vga, r_s2_miss, r_s2_gd, r_s2_dbg, r_s2_rd;

  logic              w_starve;
  logic              w_vga_win, w_vga_miss, w_game_win, w_dbg_win, w_any;
  logic [3:0]        w_sel_x;
  logic [4:0]        w_sel_y;
  logic              w_oor;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rdat;

  assign w_starve = game_req && (r_wait_cnt >= c_STARVE_LIMIT);

  always_comb begin
    w_vga_win  = 1'b0;
    w_vga_miss = 1'b0;
    w_game_win = 1'b0;
    w_dbg_win  = 1'b0;
    if (w_starve) begin
      w_game_win = 1'b1;
      w_vga_miss = vga_req;        // VGA still gets a (stale) response
    end else if (vga_req) begin
      w_vga_win = 1'b1;
    end else if (game_req && dbg_req) begin
      w_dbg_win  = r_rr_dbg;
      w_game_win = !r_rr_dbg;
    end else begin
      w_game_win = game_req;
      w_dbg_win  = dbg_req;
    end
  end

  assign w_any = w_vga_win || w_game_win || w_dbg_win;

  always_comb begin
    w_sel_x = vga_x;
    w_sel_y = vga_y;
    if (w_game_win) begin
      w_sel_x = game_x;
      w_sel_y = game_y;
    end else if (w_dbg_win) begin
      w_sel_x = dbg_x;
      w_sel_y = dbg_y;
    end
  end

  assign w_oor  = (32'(w_sel_x) >= BOARD_W) || (32'(w_sel_y) >= BOARD_H);
  assign w_addr = ADDR_W'(w_sel_y) * ADDR_W'(BOARD_W) + ADDR_W'(w_sel_x);

  // Out-of-range slots issue no read and answer with zero data
  assign w_rdat = r_s2_rd ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt  <= '0;
      r_rr_dbg    <= 1'b0;
      game_gnt    <= 1'b0;
      dbg_gnt     <= 1'b0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      r_s1_vga    <= 1'b0;
      r_s1_miss   <= 1'b0;
      r_s1_gd     <= 1'b0;
      r_s1_dbg    <= 1'b0;
      r_s2_vga    <= 1'b0;
      r_s2_miss   <= 1'b0;
      r_s2_gd     <= 1'b0;
      r_s2_dbg    <= 1'b0;
      r_s2_rd     <= 1'b0;
      vga_rvalid  <= 1'b0;
      vga_miss    <= 1'b0;
      vga_rdata   <= '0;
      game_rvalid <= 1'b0;
      game_rdata  <= '0;
      dbg_rvalid  <= 1'b0;
      dbg_rdata   <= '0;
    end else begin
      if (!game_req || w_game_win)
        r_wait_cnt <= '0;
      else if (r_wait_cnt < c_STARVE_LIMIT)
        r_wait_cnt <= r_wait_cnt + 1'b1;

      if (w_game_win || w_dbg_win)
        r_rr_dbg <= !r_rr_dbg;

      // Stage 1: grant and memory command
      game_gnt  <= w_game_win;
      dbg_gnt   <= w_dbg_win;
      mem_en    <= w_any && !w_oor;
      mem_addr  <= (w_any && !w_oor) ? w_addr : '0;
      r_s1_vga  <= w_vga_win || w_vga_miss;
      r_s1_miss <= w_vga_miss;
      r_s1_gd   <= w_game_win || w_dbg_win;
      r_s1_dbg  <= w_dbg_win;

      // Stage 2: memory is reading
      r_s2_vga  <= r_s1_vga;
      r_s2_miss <= r_s1_miss;
      r_s2_gd   <= r_s1_gd;
      r_s2_dbg  <= r_s1_dbg;
      r_s2_rd   <= mem_en;

      // Stage 3: capture memory data into the response registers
      vga_rvalid  <= r_s2_vga;
      vga_miss    <= r_s2_vga && r_s2_miss;
      if (r_s2_vga && !r_s2_miss)
        vga_rdata <= w_rdat;
      game_rvalid <= r_s2_gd && !r_s2_dbg;
      if (r_s2_gd && !r_s2_dbg)
        game_rdata <= w_rdat;
      dbg_rvalid  <= r_s2_gd && r_s2_dbg;
      if (r_s2_gd && r_s2_dbg)
        dbg_rdata <= w_rdat;
    end
  end

`ifdef BOARD_ARB_STATS_EN
  // Steps together with the vga_miss pulse it counts
  always_ff @(posedge clk) begin
    if (reset)
      stat_miss_cnt <= '0;
    else if (r_s2_vga && r_s2_miss && (stat_miss_cnt != 16'hFFFF))
      stat_miss_cnt <= stat_miss_cnt + 16'd1;
  end
`endif

endmodule
`default_nettype wire
